// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite/frame-buffer geometry, key color and state types
package sprite_pkg;

  localparam int          SPR_W     = 32;
  localparam int          SPR_H     = 32;
  localparam int          FB_W      = 640;
  localparam int          FB_H      = 480;
  localparam logic [23:0] KEY_COLOR = 24'hFF0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } blit_state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_DOWN  = 2'd3
  } sprite_dir_t;

endpackage

// File: rtl/fb_addr_calc.sv
// rtl/fb_addr_calc.sv - screen position, visibility and linear frame-buffer address
module fb_addr_calc
  import sprite_pkg::*;
(
  input  logic [9:0]  x_i,
  input  logic [9:0]  y_i,
  input  logic [4:0]  row_i,
  input  logic [4:0]  col_i,
  output logic [10:0] px_o,
  output logic [10:0] py_o,
  output logic        in_bounds_o,
  output logic [18:0] addr_o
);

  localparam logic [10:0] FB_W_L = 11'(FB_W);
  localparam logic [10:0] FB_H_L = 11'(FB_H);

  // 11-bit sums so a sprite hanging past the right/bottom edge is detected, not wrapped
  assign px_o        = {1'b0, x_i} + {6'b0, col_i};
  assign py_o        = {1'b0, y_i} + {6'b0, row_i};
  assign in_bounds_o = (px_o < FB_W_L) && (py_o < FB_H_L);
  assign addr_o      = 19'(py_o) * 19'(FB_W) + 19'(px_o);

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - copies one 32x32 sprite from ROM into the frame buffer with keying and clipping
module sprite_blitter
  import sprite_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [9:0]  spriteX,
  input  logic [9:0]  spriteY,
  input  logic [1:0]  sprite_sel,
  output logic [11:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [23:0] fb_data,
  input  logic        fb_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] ROW_LAST = 5'(SPR_H - 1);
  localparam logic [4:0] COL_LAST = 5'(SPR_W - 1);

  blit_state_t state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [4:0]  col_q, col_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [1:0]  sel_q, sel_d;

  logic [10:0] px, py;
  logic        in_bounds;
  logic [18:0] calc_addr;
  logic        skip;
  logic        write_req;

  fb_addr_calc u_addr (
    .x_i         (x_q),
    .y_i         (y_q),
    .row_i       (row_q),
    .col_i       (col_q),
    .px_o        (px),
    .py_o        (py),
    .in_bounds_o (in_bounds),
    .addr_o      (calc_addr)
  );

  // px/py exist for the color mapper's read path; visibility already folds them in here
  logic unused_px_py;
  assign unused_px_py = ^{px, py};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
    end
  end

  assign skip      = (rom_data == KEY_COLOR) || !in_bounds;
  assign write_req = (state_q == WRITE) && !skip;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    x_d     = x_q;
    y_d     = y_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = spriteX;
          y_d     = spriteY;
          sel_d   = sprite_sel;
          row_d   = '0;
          col_d   = '0;
          state_d = READ;
        end
      end
      READ: state_d = WRITE;
      WRITE: begin
        if (skip || fb_ready) begin
          if (row_q == ROW_LAST && col_q == COL_LAST) begin
            state_d = DONE;
          end else begin
            state_d = READ;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + 5'd1;
            end else begin
              col_d = col_q + 5'd1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rom_addr is purely registered, so it stays put for the whole WRITE stall
  assign rom_addr = {sel_q, row_q, col_q};
  assign fb_we    = write_req;
  assign fb_addr  = write_req ? calc_addr : '0;
  assign fb_data  = write_req ? rom_data : '0;
  assign busy     = (state_q == READ) || (state_q == WRITE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - scoreboard bench for sprite_blitter
module tb_sprite_blitter;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  spriteX = '0;
  logic [9:0]  spriteY = '0;
  logic [1:0]  sprite_sel = '0;
  logic [11:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [23:0] fb_data;
  logic        fb_ready = 1'b1;
  logic        busy;
  logic        done;

  sprite_blitter dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .start      (start),
    .spriteX    (spriteX),
    .spriteY    (spriteY),
    .sprite_sel (sprite_sel),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_ready   (fb_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 Clk = ~Clk;

  logic [23:0] rom [0:4095];
  always @(posedge Clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int          n_pass = 0;
  int          n_total = 0;
  logic [42:0] wr_q[$];
  int          lat_q[$];
  int          start_cyc = 0;
  int          writes_seen = 0;
  int          dones_seen = 0;
  logic [18:0] first_addr = '0;
  logic [18:0] last_addr = '0;
  logic [18:0] max_addr = '0;
  logic        saw_32101 = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge Clk) begin
    if (Reset_n) begin
      if (fb_we && fb_ready) begin
        logic [42:0] e;
        if (writes_seen == 0) first_addr = fb_addr;
        last_addr = fb_addr;
        if (fb_addr > max_addr) max_addr = fb_addr;
        if (fb_addr == 19'd32101) saw_32101 = 1'b1;
        writes_seen++;
        if (wr_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = wr_q.pop_front();
          check("fb_addr", fb_addr, e[42:24]);
          check("fb_data", fb_data, e[23:0]);
        end
      end
      if (done) begin
        dones_seen++;
        check("busy_at_done", busy, 0);
        if (lat_q.size() == 0) check("unexpected_done", 1, 0);
        else check("done_latency", cyc - start_cyc + 1, lat_q.pop_front());
      end
    end
  end

  task automatic fill_rom(input logic [23:0] v);
    for (int i = 0; i < 4096; i++) rom[i] = v;
  endtask

  task automatic push_expected(input int x, input int y, input int sel);
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        int          px, py;
        logic [23:0] pix;
        px  = x + c;
        py  = y + r;
        pix = rom[sel * 1024 + r * 32 + c];
        if (pix != 24'hFF0000 && px < 640 && py < 480)
          wr_q.push_back({19'(py * 640 + px), pix});
      end
    end
  endtask

  task automatic run_blit(input int x, input int y, input int sel, input int lat, input int exp_writes);
    int d0;
    writes_seen = 0;
    max_addr    = '0;
    saw_32101   = 1'b0;
    d0          = dones_seen;
    push_expected(x, y, sel);
    lat_q.push_back(lat);
    @(posedge Clk); #1;
    start = 1'b1; spriteX = 10'(x); spriteY = 10'(y); sprite_sel = 2'(sel);
    @(posedge Clk); #1;
    start     = 1'b0;
    start_cyc = cyc;
    @(negedge Clk);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 3000 && dones_seen == d0; i++) @(posedge Clk);
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    check("done_count", dones_seen - d0, 1);
    check("busy_after_done", busy, 0);
    check("write_count", writes_seen, exp_writes);
    check("writes_left", wr_q.size(), 0);
    wr_q.delete();
    lat_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [18:0] ha;
    logic [23:0] hd;
    int          d0;

    // reset held with start asserted
    fill_rom(24'h00FF00);
    start = 1'b1; spriteX = 10'd100; spriteY = 10'd50;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_fb_we", fb_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_rom_addr", rom_addr, 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1; start = 1'b0;

    // full opaque blit
    run_blit(100, 50, 0, 2049, 1024);
    check("first_addr", first_addr, 32100);
    check("last_addr", last_addr, 51971);

    // transparency in sprite 3, sprite 0 left opaque to expose sel errors
    fill_rom(24'h123456);
    rom[3 * 1024 + 1] = 24'hFF0000;
    rom[1]            = 24'h000001;
    run_blit(100, 50, 3, 2049, 1023);
    check("key_not_written", saw_32101, 0);

    // clipping at bottom-right corner
    fill_rom(24'h00FF00);
    run_blit(620, 470, 0, 2049, 200);
    check("clip_max_addr", max_addr, 307199);

    // back-pressure on the first write
    fb_ready = 1'b0;
    fork
      run_blit(10, 20, 0, 2052, 1024);
      begin
        @(negedge Clk);
        for (int i = 0; i < 100 && !fb_we; i++) @(negedge Clk);
        check("stall_we", fb_we, 1);
        check("stall_first_addr", fb_addr, 12810);
        ha = fb_addr; hd = fb_data;
        repeat (2) begin
          @(posedge Clk); #1;
          @(negedge Clk);
          check("stall_hold_we", fb_we, 1);
          check("stall_hold_addr", fb_addr, ha);
          check("stall_hold_data", fb_data, hd);
        end
        @(posedge Clk); #1;
        fb_ready = 1'b1;
        @(negedge Clk);
        check("stall_last_we", fb_we, 1);
        check("stall_last_addr", fb_addr, ha);
        check("stall_last_data", fb_data, hd);
      end
    join

    // mid-blit reset: 250 pixels land, then the blit is abandoned
    writes_seen = 0;
    d0 = dones_seen;
    push_expected(0, 0, 0);
    @(posedge Clk); #1;
    start = 1'b1; spriteX = 10'd0; spriteY = 10'd0; sprite_sel = 2'd0;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (500) @(posedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check("midrst_fb_we", fb_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rom_addr", rom_addr, 0);
    check("midrst_writes", writes_seen, 250);
    wr_q.delete();
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (50) @(posedge Clk);
    check("midrst_no_done", dones_seen - d0, 0);

    // start pulsed while busy is ignored
    fork
      run_blit(200, 100, 1, 2049, 1024);
      begin
        repeat (20) @(posedge Clk);
        #1 start = 1'b1; spriteX = 10'd5;
        @(posedge Clk); #1 start = 1'b0;
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Writer side of the sprite/frame RAM path: copies one 32x32 tank sprite from the sprite ROM into the 640x480 frame buffer at a given top-left position.
- Skips pixels equal to the transparency key 24'hFF0000.
- Clips pixels outside the screen.
- Sits between the game logic (issues start per sprite draw) and the frame buffer write port; the color mapper reads the result.

Parameters:
- SPR_W, 32, sprite width in pixels
- SPR_H, 32, sprite height in pixels
- FB_W, 640, frame buffer width
- FB_H, 480, frame buffer height
- KEY_COLOR, 24'hFF0000, transparent color, never written

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a blit; sampled only in IDLE
- spriteX  in  10  top-left X of sprite on screen
- spriteY  in  10  top-left Y of sprite on screen
- sprite_sel  in  2  sprite image: 0 up, 1 right, 2 left, 3 down
- rom_addr  out  12  sprite ROM address = sel*1024 + row*32 + col
- rom_data  in  24  ROM pixel {R,G,B}, valid one cycle after rom_addr
- fb_we  out  1  frame buffer write request
- fb_addr  out  19  frame buffer address = (Y+row)*FB_W + (X+col)
- fb_data  out  24  pixel written
- fb_ready  in  1  frame buffer accepts the write this cycle when high with fb_we
- busy  out  1  high while a blit is in progress
- done  out  1  one-cycle pulse at blit completion

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - State goes to IDLE; row=col=0; latched X, Y and sel cleared.
  - Outputs: fb_we=0, busy=0, done=0, rom_addr=0, fb_addr=0, fb_data=0.
  - Reset asserted mid-blit abandons the blit immediately. Pixels already written stay written. No done pulse.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - busy=0.
  - On start=1: latch spriteX, spriteY and sprite_sel; set row=col=0; go to READ.
- READ:
  - busy=1; rom_addr driven from latched sel, row and col.
  - Go to WRITE next cycle.
- WRITE:
  - busy=1; rom_data is valid.
  - px = X+col and py = Y+row, each computed 11 bits wide.
  - skip = (rom_data==KEY_COLOR) OR px>=FB_W OR py>=FB_H.
  - If skip: fb_we=0; advance.
  - Else: fb_we=1, fb_addr=py*FB_W+px truncated to 19 bits, fb_data=rom_data.
    - fb_ready=1: advance.
    - fb_ready=0: stay in WRITE, holding fb_we, fb_addr and fb_data stable.
  - rom_addr stays stable in WRITE, so rom_data remains valid across stalls.
- Advance:
  - If row==SPR_H-1 and col==SPR_W-1: go to DONE.
  - Else: col+1, wrapping to 0 with row+1 at SPR_W-1; go to READ.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
- start is ignored in READ, WRITE and DONE; a new start is accepted in IDLE only.
- fb_we, busy and done are decoded from the registered state, with no combinational path from start.
- Timing, fb_ready held 1: start sampled at edge 0.
  - First WRITE cycle is 2.
  - Each pixel takes 2 cycles, so done pulses 2*SPR_W*SPR_H+1 = 2049 cycles after start.
  - Skipped pixels take the same 2 cycles, so timing is independent of content.
- Partially off-screen sprites:
  - Visible pixels are written.
  - No wrap to the next line or into address space beyond 307199.

Decomposition:
- Package sprite_pkg:
  - SPR_W, SPR_H, FB_W, FB_H, KEY_COLOR
  - enum blit_state_t {IDLE, READ, WRITE, DONE}
  - enum sprite_dir_t {DIR_UP=0, DIR_RIGHT=1, DIR_LEFT=2, DIR_DOWN=3}
- Sub-module fb_addr_calc (combinational):
  - Takes X, Y, row, col.
  - Produces px, py, in_bounds and the 19-bit fb_addr.
  - Shared later with the color mapper for read-address generation.

Test Plan:
- Reset: hold Reset_n=0 with start=1 -> fb_we=0, busy=0, done=0; release, pulse start with X=100, Y=50, sel=0 -> busy=1 from the next cycle.
- Full opaque blit: ROM all 24'h00FF00, fb_ready=1, X=100, Y=50 -> 1024 writes.
  - First write fb_addr=50*640+100=32100; last write (81*640)+131=51971.
  - done pulses once at cycle 2049; busy=0 afterwards.
- Transparency: ROM pixel (row 0, col 1) = 24'hFF0000, others 24'h123456 -> address 32101 never written, 1023 writes, done still at cycle 2049.
- Clipping: X=620, Y=470 -> only col 0..19 and row 0..9 written (200 writes); no fb_addr >= 307200; done at 2049.
- Back-pressure: fb_ready=0 for 3 cycles on the first opaque write -> fb_we, fb_addr and fb_data held unchanged for 4 cycles; done delayed by exactly 3 cycles.
- Mid-blit reset and ignored start: assert Reset_n=0 at cycle 500 -> fb_we=0 and state IDLE immediately, no done. Pulse start while busy -> ignored, one done per accepted start.
